// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write-back bypass and a per-register
// pending-write scoreboard whose busy flags feed the decode-stage stall logic.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_RD-1:0]          re,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       iss_vld,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (ADDR_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Storage: entry 0 is never written, so it stays zero from reset onward.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    // Scoreboard next state: flush beats issue, issue beats write-back clear.
    always_comb begin
        pending_nxt = pending;
        pending_nxt[0] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            if (flush) begin
                pending_nxt[r] = 1'b0;
            end else if (iss_vld && iss_addr == ADDR_W'(r)) begin
                pending_nxt[r] = 1'b1;
            end else if (we && waddr == ADDR_W'(r)) begin
                pending_nxt[r] = 1'b0;
            end
        end
    end

    // Count is registered alongside the pending bits so both move together.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= popcount(pending_nxt);
        end
    end

    // Read ports: a matching write-back supplies the data and clears the hazard.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [ADDR_W-1:0] a;
            logic              hit;
            a   = raddr[i*ADDR_W +: ADDR_W];
            hit = we && (waddr == a);
            if (rst_ && re[i] && a != '0) begin
                rdata[i*DATA_W +: DATA_W] = hit ? wdata : mem[a];
                rbusy[i]                  = pending[a] && !hit;
            end
        end
    end

endmodule
